alarm_responder: RTL and testbench

// - Sequential back end for the entry-alarm logic: consumes the combinational

---
 rtl/alarm_responder.sv | 123 ++++++++++++
 tb/tb_alarm_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alarm_responder.sv
// Alarm sequencer: arm/disarm by keypad code, entry delay, timed siren, latched trip indication.
// Optional LOCKOUT_EN macro: three consecutive bad codes while ARMED/ENTRY force the alarm.
module alarm_responder #(
  parameter int                ENTRY_DLY   = 16,
  parameter int                SIREN_TIME  = 64,
  parameter int                CODE_W      = 4,
  parameter logic [CODE_W-1:0] DISARM_CODE = CODE_W'(5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trip,
  input  logic              arm,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              armed,
  output logic              pending,
  output logic              siren,
  output logic              tripped,
  output logic              code_err
);

  localparam int MAX_CNT = (ENTRY_DLY > SIREN_TIME) ? ENTRY_DLY : SIREN_TIME;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME - 1);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    ENTRY    = 3'd2,
    ALARM    = 3'd3,
    TRIPPED  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_code_err;

  logic w_good;
  logic w_bad;
  logic w_lock;

  assign w_good = code_valid && (code == DISARM_CODE);
  assign w_bad  = code_valid && (code != DISARM_CODE);

`ifdef LOCKOUT_EN
  logic [1:0] r_bad_cnt;

  // Third consecutive bad code; only acted on in ARMED/ENTRY by the FSM.
  assign w_lock = w_bad && (r_bad_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bad_cnt <= 2'd0;
    end else if (w_good || r_state == DISARMED) begin
      r_bad_cnt <= 2'd0;
    end else if (w_bad && r_bad_cnt != 2'd3) begin
      r_bad_cnt <= r_bad_cnt + 2'd1;
    end
  end
`else
  assign w_lock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DISARMED;
      r_cnt      <= '0;
      r_code_err <= 1'b0;
    end else begin
      r_code_err <= w_bad && (r_state != DISARMED);
      case (r_state)
        DISARMED: begin
          if (arm) r_state <= ARMED;
        end
        ARMED: begin
          if (w_good) begin
            r_state <= DISARMED;
          end else if (w_lock) begin
            r_state <= ALARM;
            r_cnt   <= SIREN_LD;
          end else if (trip) begin
            r_state <= ENTRY;
            r_cnt   <= ENTRY_LD;
          end
        end
        ENTRY: begin
          if (w_good) begin
            r_state <= DISARMED;
          end else if (w_lock || r_cnt == '0) begin
            r_state <= ALARM;
            r_cnt   <= SIREN_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ALARM: begin
          // Counter parks at zero once the siren period expires.
          if (w_good) begin
            r_state <= DISARMED;
          end else if (r_cnt == '0) begin
            r_state <= TRIPPED;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        TRIPPED: begin
          if (w_good) r_state <= DISARMED;
        end
        default: begin
          r_state <= DISARMED;
        end
      endcase
    end
  end

  assign armed    = (r_state != DISARMED);
  assign pending  = (r_state == ENTRY);
  assign siren    = (r_state == ALARM);
  assign tripped  = (r_state == TRIPPED);
  assign code_err = r_code_err;

endmodule

// File: tb/tb_alarm_responder.sv
// Table-driven bench for alarm_responder with ENTRY_DLY=4, SIREN_TIME=8, DISARM_CODE=5.
module tb_alarm_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trip = 1'b0;
  logic       arm = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code = 4'h0;
  logic       armed, pending, siren, tripped, code_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alarm_responder #(
    .ENTRY_DLY  (4),
    .SIREN_TIME (8),
    .CODE_W     (4),
    .DISARM_CODE(4'h5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trip      (trip),
    .arm       (arm),
    .code_valid(code_valid),
    .code      (code),
    .armed     (armed),
    .pending   (pending),
    .siren     (siren),
    .tripped   (tripped),
    .code_err  (code_err)
  );

  typedef struct {
    logic       rst;
    logic       trip;
    logic       arm;
    logic       cv;
    logic [3:0] code;
    logic [4:0] exp; // {armed, pending, siren, tripped, code_err} after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic t, input logic a,
                              input logic cv, input logic [3:0] c, input logic [4:0] e);
    vec_t v;
    v.rst = r; v.trip = t; v.arm = a; v.cv = cv; v.code = c; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic r, input logic t, input logic a,
                       input logic cv, input logic [3:0] c);
    rst = r; trip = t; arm = a; code_valid = cv; code = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {armed, pending, siren, tripped, code_err};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got apstc=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // {armed, pending, siren, tripped, code_err}
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 5'b00000)); // v0 reset
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 5'b00000));
    vecs.push_back(mk(0, 1, 0, 1, 4'h3, 5'b00000)); // disarmed ignores trip and bad code
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 5'b10000)); // arm
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 5'b10000)); // arm while armed ignored
    vecs.push_back(mk(0, 0, 0, 1, 4'h3, 5'b10001)); // bad code in ARMED
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b10000)); // code_err one cycle only
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 5'b11000)); // trip at n
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 5'b11000)); // n+1
    vecs.push_back(mk(0, 0, 0, 1, 4'h5, 5'b00000)); // good code at n+2
    vecs.push_back(mk(0, 0, 1, 1, 4'h5, 5'b10000)); // arm + good code in DISARMED
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 5'b11000)); // trip at n
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b11000));
    vecs.push_back(mk(0, 0, 0, 1, 4'h3, 5'b11001)); // bad code in ENTRY
    vecs.push_back(mk(0, 0, 0, 1, 4'h5, 5'b00000)); // good code
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 5'b10000)); // arm
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 5'b11000)); // trip at n
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b11000));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b11000));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b11000)); // n+3
    vecs.push_back(mk(0, 0, 0, 1, 4'h5, 5'b00000)); // good code on expiry edge wins
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 5'b10000)); // arm
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 5'b11000)); // trip at n
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b11000));
    for (int i = 4; i <= 11; i++)
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b10100)); // siren n+4..n+11
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 5'b10010)); // n+12 tripped
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 5'b10010)); // trip ignored
    vecs.push_back(mk(0, 0, 0, 1, 4'h3, 5'b10011)); // bad code in TRIPPED
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 5'b10010)); // arm ignored
    vecs.push_back(mk(0, 0, 0, 1, 4'h5, 5'b00000)); // disarm

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].trip, vecs[i].arm, vecs[i].cv, vecs[i].code);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset then 20 cycles of trip without arm: never armed or sounding.
    drive(1, 0, 0, 0, 4'h0);
    drive(1, 0, 0, 0, 4'h0);
    check("rst_state", 5'b00000);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 4'h0);
      check($sformatf("trip_unarmed%0d", i), 5'b00000);
    end

    // Reset asserted in ALARM at siren cycle 3, then a fresh arm.
    drive(0, 0, 1, 0, 4'h0);
    drive(0, 1, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 4'h0);
    drive(0, 0, 0, 0, 4'h0);
    check("alarm_rise", 5'b10100);
    drive(0, 0, 0, 0, 4'h0);
    drive(0, 0, 0, 0, 4'h0);
    check("alarm_cyc3", 5'b10100);
    drive(1, 0, 0, 0, 4'h0);
    check("rst_in_alarm", 5'b00000);
    drive(0, 0, 1, 0, 4'h0);
    check("rearm", 5'b10000);
    drive(0, 1, 0, 0, 4'h0);
    check("rearm_entry", 5'b11000);

    // Three consecutive bad codes in ENTRY (trip at n, codes at n+1..n+3).
    drive(0, 0, 0, 1, 4'h3);
    check("bad1", 5'b11001);
    drive(0, 0, 0, 1, 4'h3);
    check("bad2", 5'b11001);
    drive(0, 0, 0, 1, 4'h3);
`ifdef LOCKOUT_EN
    check("bad3_lockout", 5'b10101);
    drive(0, 0, 0, 0, 4'h0);
    check("lockout_hold", 5'b10100);
`else
    check("bad3", 5'b11001);
    drive(0, 0, 0, 0, 4'h0);
    check("bad3_expiry", 5'b10100);
`endif
    drive(0, 0, 0, 1, 4'h5);
    check("final_disarm", 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
